// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier-sharing controller: FSM state
// encoding, default sizes and a helper for index widths.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_NREQ  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Bits needed to hold a requester index (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_share_ctrl_if.sv
// Bundle of requester-side and multiplier-side signals of the sharing
// controller. The controller uses the slave view; the environment the master.
interface mult_share_ctrl_if #(
    parameter int WIDTH = mult_pkg::DEFAULT_WIDTH,
    parameter int NREQ  = mult_pkg::DEFAULT_NREQ
);
    // Requester side
    logic [NREQ-1:0]       Req;
    logic [NREQ*WIDTH-1:0] Req_A;
    logic [NREQ*WIDTH-1:0] Req_B;
    logic [NREQ-1:0]       Gnt;
    logic                  Rsp_Valid;
    logic [2:0]            Rsp_Id;
    logic [2*WIDTH-1:0]    Rsp_Product;
    logic                  Rsp_Err;
    logic                  Busy;
    // Multiplier side
    logic [WIDTH-1:0]      Mul_Mcand;
    logic [WIDTH-1:0]      Mul_Mplier;
    logic                  Mul_St;
    logic                  Mul_Rst;
    logic                  Mul_Done;
    logic [2*WIDTH-1:0]    Mul_Product;

    modport slave (
        input  Req, Req_A, Req_B, Mul_Done, Mul_Product,
        output Gnt, Rsp_Valid, Rsp_Id, Rsp_Product, Rsp_Err, Busy,
               Mul_Mcand, Mul_Mplier, Mul_St, Mul_Rst
    );

    modport master (
        output Req, Req_A, Req_B, Mul_Done, Mul_Product,
        input  Gnt, Rsp_Valid, Rsp_Id, Rsp_Product, Rsp_Err, Busy,
               Mul_Mcand, Mul_Mplier, Mul_St, Mul_Rst
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after
// the pointer, wrapping around. Returns one-hot and index forms of the winner.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // Scan requesters in priority order starting at the pointer.
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand = IDX_W'((int'(ptr_i) + off) % NREQ);
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                idx_o        = cand;
                gnt_o[cand]  = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one shift-add multiplier between NREQ requesters: round-robin
// grant, operand capture, start pulse, wait for Done (with watchdog),
// then a one-cycle response tagged with the winner's index.
module mult_share_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int NREQ    = DEFAULT_NREQ,
    parameter int MAX_CYC = 2 * WIDTH + 4
) (
    input  logic             Clk,
    input  logic             Reset,
    mult_share_ctrl_if.slave bus
);

    localparam int IDX_W = idx_width(NREQ);
    localparam int TMR_W = $clog2(MAX_CYC + 1);

    state_t             state_q,  state_d;
    logic [IDX_W-1:0]   ptr_q,    ptr_d;
    logic [IDX_W-1:0]   win_q,    win_d;
    logic [NREQ-1:0]    gnt_q,    gnt_d;
    logic [WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [TMR_W-1:0]   timer_q,  timer_d;
    logic [2*WIDTH-1:0] prod_q,   prod_d;
    logic               err_q,    err_d;
    logic               mul_rst;

    logic [NREQ-1:0]    arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i (bus.Req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Next-state and datapath updates for the IDLE/ISSUE/WAIT/RESP sequence.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        gnt_d    = gnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        timer_d  = timer_q;
        prod_d   = prod_q;
        err_d    = err_q;
        mul_rst  = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    win_d = arb_idx;
                    gnt_d = arb_gnt;
                    for (int i = 0; i < NREQ; i++) begin
                        if (arb_idx == IDX_W'(i)) begin
                            mcand_d  = bus.Req_A[i*WIDTH +: WIDTH];
                            mplier_d = bus.Req_B[i*WIDTH +: WIDTH];
                        end
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                ptr_d   = (win_q == IDX_W'(NREQ - 1)) ? '0 : win_q + 1'b1;
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + 1'b1;
                // Done wins over a watchdog expiry in the same cycle.
                if (bus.Mul_Done) begin
                    prod_d  = bus.Mul_Product;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timer_q == TMR_W'(MAX_CYC)) begin
                    mul_rst = 1'b1;
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: operand and result registers are reset as well, because they
    // reach ports that must read zero straight out of reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            gnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            timer_q  <= '0;
            prod_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            gnt_q    <= gnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            timer_q  <= timer_d;
            prod_q   <= prod_d;
            err_q    <= err_d;
        end
    end

    // Pulses are decoded from the state so each lasts exactly one cycle.
    assign bus.Gnt         = (state_q == ISSUE) ? gnt_q : '0;
    assign bus.Mul_St      = (state_q == ISSUE);
    assign bus.Mul_Rst     = mul_rst;
    assign bus.Mul_Mcand   = mcand_q;
    assign bus.Mul_Mplier  = mplier_q;
    assign bus.Busy        = (state_q != IDLE);
    assign bus.Rsp_Valid   = (state_q == RESP);
    assign bus.Rsp_Id      = (state_q == RESP) ? 3'(win_q) : 3'd0;
    assign bus.Rsp_Product = (state_q == RESP) ? prod_q : '0;
    assign bus.Rsp_Err     = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed and randomized bench for mult_share_ctrl with a behavioural
// multiplier peer and a round-robin reference model.
module tb_mult_share_ctrl;
    import mult_pkg::*;

    localparam int WIDTH   = 16;
    localparam int NREQ    = 2;
    localparam int MAX_CYC = 2 * WIDTH + 4;
    localparam int PW      = 2 * WIDTH;
    localparam int LAT_OK  = 35;   // grant -> Rsp_Valid with Done in cycle 34
    localparam int LAT_ERR = 38;   // grant -> Rsp_Valid on watchdog expiry

    logic Clk;
    logic Reset;

    mult_share_ctrl_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    mult_share_ctrl #(
        .WIDTH   (WIDTH),
        .NREQ    (NREQ),
        .MAX_CYC (MAX_CYC)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc_cnt = 0;
    int unsigned grant_cyc = 0;
    int          ptr_m = 0;
    bit          hang = 1'b0;
    bit          spur = 1'b0;
    int          done_lat = 33;

    logic [WIDTH-1:0] a_tb [NREQ];
    logic [WIDTH-1:0] b_tb [NREQ];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        forever begin
            @(posedge Clk);
            cyc_cnt++;
        end
    end

    // Behavioural multiplier: Done one cycle, done_lat cycles after St.
    initial begin : mul_model
        bit              running;
        bit              fire;
        int              cnt;
        logic [PW-1:0]   p;
        running = 1'b0;
        cnt     = 0;
        p       = '0;
        bus.Mul_Done    = 1'b0;
        bus.Mul_Product = '0;
        forever begin
            @(negedge Clk);
            fire = 1'b0;
            if (bus.Mul_Rst || !bus.Busy) begin
                running = 1'b0;
            end else if (bus.Mul_St) begin
                running = 1'b1;
                cnt     = 0;
                p       = PW'(bus.Mul_Mcand) * PW'(bus.Mul_Mplier);
            end else if (running) begin
                cnt++;
            end
            if (running && !hang && cnt == done_lat) begin
                fire    = 1'b1;
                running = 1'b0;
            end
            @(posedge Clk);
            #1;
            bus.Mul_Done    = fire || spur;
            bus.Mul_Product = fire ? p : (spur ? PW'(32'hDEAD_BEEF) : '0);
            spur            = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference round-robin choice: first requester at or after ptr, wrapping.
    function automatic int pick(input logic [NREQ-1:0] req, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (req[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) begin
            bus.Req_A[i*WIDTH +: WIDTH] = a_tb[i];
            bus.Req_B[i*WIDTH +: WIDTH] = b_tb[i];
        end
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b1;
        @(negedge Clk);
        check({tag, ".gnt"},    64'(bus.Gnt),         64'(0));
        check({tag, ".busy"},   64'(bus.Busy),        64'(0));
        check({tag, ".valid"},  64'(bus.Rsp_Valid),   64'(0));
        check({tag, ".id"},     64'(bus.Rsp_Id),      64'(0));
        check({tag, ".prod"},   64'(bus.Rsp_Product), 64'(0));
        check({tag, ".err"},    64'(bus.Rsp_Err),     64'(0));
        check({tag, ".st"},     64'(bus.Mul_St),      64'(0));
        check({tag, ".mrst"},   64'(bus.Mul_Rst),     64'(0));
        check({tag, ".mcand"},  64'(bus.Mul_Mcand),   64'(0));
        check({tag, ".mplier"}, 64'(bus.Mul_Mplier),  64'(0));
        Reset = 1'b0;
        ptr_m = 0;
    endtask

    task automatic wait_grant(input string tag, input int exp_w, input int exp_lat);
        int n;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (bus.Gnt == '0 && n < 200);
        check({tag, ".gnt"},    64'(bus.Gnt),        64'(1) << exp_w);
        check({tag, ".glat"},   64'(n),              64'(exp_lat));
        check({tag, ".st"},     64'(bus.Mul_St),     64'(1));
        check({tag, ".mcand"},  64'(bus.Mul_Mcand),  64'(a_tb[exp_w]));
        check({tag, ".mplier"}, 64'(bus.Mul_Mplier), 64'(b_tb[exp_w]));
        grant_cyc = cyc_cnt;
        ptr_m     = (exp_w + 1) % NREQ;
    endtask

    task automatic wait_rsp(input string tag, input int exp_w, input logic [PW-1:0] exp_p,
                            input bit exp_err, input int exp_lat, input int exp_rst_at);
        int n;
        int rst_cnt;
        int rst_at;
        int g_cnt;
        n = 0; rst_cnt = 0; rst_at = 0; g_cnt = 0;
        do begin
            @(negedge Clk);
            n++;
            if (bus.Mul_Rst) begin
                rst_cnt++;
                rst_at = int'(cyc_cnt - grant_cyc);
            end
            if (bus.Gnt != '0) g_cnt++;
        end while (!bus.Rsp_Valid && n < 200);
        check({tag, ".valid"},  64'(bus.Rsp_Valid),         64'(1));
        check({tag, ".rlat"},   64'(cyc_cnt - grant_cyc),   64'(exp_lat));
        check({tag, ".id"},     64'(bus.Rsp_Id),            64'(exp_w));
        check({tag, ".prod"},   64'(bus.Rsp_Product),       64'(exp_p));
        check({tag, ".err"},    64'(bus.Rsp_Err),           64'(exp_err));
        check({tag, ".nrst"},   64'(rst_cnt),               64'(exp_rst_at > 0 ? 1 : 0));
        if (exp_rst_at > 0)
            check({tag, ".rst_at"}, 64'(rst_at), 64'(exp_rst_at));
        check({tag, ".busygnt"}, 64'(g_cnt), 64'(0));
        @(negedge Clk);
        check({tag, ".pulse"},  64'(bus.Rsp_Valid), 64'(0));
        check({tag, ".idle"},   64'(bus.Busy),      64'(0));
    endtask

    task automatic quiet(input string tag, input int cycles);
        int v;
        int g;
        v = 0; g = 0;
        repeat (cycles) begin
            @(negedge Clk);
            if (bus.Rsp_Valid) v++;
            if (bus.Gnt != '0) g++;
        end
        check({tag, ".novalid"}, 64'(v), 64'(0));
        check({tag, ".nogrant"}, 64'(g), 64'(0));
    endtask

    initial begin : stim
        logic [NREQ-1:0] mask;
        logic [NREQ-1:0] pending;
        int              w;

        Reset   = 1'b1;
        bus.Req = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_tb[i] = '0;
            b_tb[i] = '0;
        end
        drive_ops();
        do_reset("rst0");

        // 1: single request, 3 * 5
        a_tb[0] = 16'd3; b_tb[0] = 16'd5; drive_ops();
        bus.Req = 2'b01;
        wait_grant("t1", 0, 1);
        bus.Req = 2'b00;
        wait_rsp("t1", 0, 32'd15, 1'b0, LAT_OK, 0);

        // 2: both held from pointer 0 -> grants 0,1,0,1
        do_reset("t2.rst");
        a_tb[0] = 16'd7; b_tb[0] = 16'd6; a_tb[1] = 16'd9; b_tb[1] = 16'd9; drive_ops();
        bus.Req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_grant($sformatf("t2.%0d", k), k % 2, 1);
            wait_rsp($sformatf("t2.%0d", k), k % 2, (k % 2) ? 32'd81 : 32'd42, 1'b0, LAT_OK, 0);
        end
        bus.Req = 2'b00;

        // 3: hung multiplier -> watchdog, then a normal request
        hang = 1'b1;
        a_tb[0] = 16'd2; b_tb[0] = 16'd3; drive_ops();
        bus.Req = 2'b01;
        wait_grant("t3.hang", 0, 1);
        bus.Req = 2'b00;
        wait_rsp("t3.hang", 0, '0, 1'b1, LAT_ERR, MAX_CYC + 1);
        hang = 1'b0;
        a_tb[0] = 16'd4; b_tb[0] = 16'd5; drive_ops();
        bus.Req = 2'b01;
        wait_grant("t3.ok", 0, 1);
        bus.Req = 2'b00;
        wait_rsp("t3.ok", 0, 32'd20, 1'b0, LAT_OK, 0);

        // Done arriving in the very cycle the timer expires is a success
        done_lat = MAX_CYC;
        a_tb[1] = 16'd100; b_tb[1] = 16'd200; drive_ops();
        bus.Req = 2'b10;
        wait_grant("t3.edge", 1, 1);
        bus.Req = 2'b00;
        wait_rsp("t3.edge", 1, 32'd20000, 1'b0, LAT_ERR, 0);
        done_lat = 33;

        // 4: reset during WAIT aborts silently; then requester 1 is served
        a_tb[0] = 16'd3; b_tb[0] = 16'd4; drive_ops();
        bus.Req = 2'b01;
        wait_grant("t4.a", 0, 1);
        bus.Req = 2'b00;
        repeat (10) @(negedge Clk);
        do_reset("t4.rst");
        quiet("t4.abort", 45);
        a_tb[1] = 16'd11; b_tb[1] = 16'd13; drive_ops();
        bus.Req = 2'b10;
        wait_grant("t4.b", 1, 1);
        bus.Req = 2'b00;
        wait_rsp("t4.b", 1, 32'd143, 1'b0, LAT_OK, 0);

        // 5: stray Done while idle; one-cycle Req pulse answered exactly once
        spur = 1'b1;
        quiet("t5.spur", 5);
        a_tb[0] = 16'd5; b_tb[0] = 16'd7; drive_ops();
        bus.Req = 2'b01;
        wait_grant("t5", 0, 1);
        bus.Req = 2'b00;
        wait_rsp("t5", 0, 32'd35, 1'b0, LAT_OK, 0);
        quiet("t5.once", 40);

        // 6: full-scale operands
        a_tb[1] = 16'hFFFF; b_tb[1] = 16'hFFFF; drive_ops();
        bus.Req = 2'b10;
        wait_grant("t6", 1, 1);
        bus.Req = 2'b00;
        wait_rsp("t6", 1, 32'hFFFE_0001, 1'b0, LAT_OK, 0);

        // 7: a request raised and dropped while busy is never granted
        a_tb[0] = 16'd21; b_tb[0] = 16'd2; drive_ops();
        bus.Req = 2'b01;
        wait_grant("t7", 0, 1);
        bus.Req = 2'b00;
        repeat (5) @(negedge Clk);
        bus.Req = 2'b10;
        repeat (5) @(negedge Clk);
        bus.Req = 2'b00;
        wait_rsp("t7", 0, 32'd42, 1'b0, LAT_OK, 0);
        quiet("t7.drop", 40);

        // Random request mixes checked against the round-robin model
        for (int it = 0; it < 8; it++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                a_tb[i] = WIDTH'($urandom);
                b_tb[i] = WIDTH'($urandom);
            end
            drive_ops();
            pending = mask;
            bus.Req = pending;
            while (pending != '0) begin
                w = pick(pending, ptr_m);
                wait_grant($sformatf("rnd%0d.w%0d", it, w), w, 1);
                pending[w] = 1'b0;
                bus.Req    = pending;
                wait_rsp($sformatf("rnd%0d.w%0d", it, w), w,
                         PW'(a_tb[w]) * PW'(b_tb[w]), 1'b0, LAT_OK, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
